// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and packed-complex helpers.
// Samples are packed as {re, im}, each component a signed Q2.14 value.
package fft_pkg;

    localparam int DW       = 16;
    localparam int FRAC     = 14;
    localparam int K_HSQRT2 = 11585;
    localparam int CPLX_W   = 2 * DW;
    localparam int SW       = DW + 1;
    localparam int PW       = 32;

    function automatic logic signed [DW-1:0] cplx_re(input logic [CPLX_W-1:0] x);
        return $signed(x[CPLX_W-1:DW]);
    endfunction

    function automatic logic signed [DW-1:0] cplx_im(input logic [CPLX_W-1:0] x);
        return $signed(x[DW-1:0]);
    endfunction

    function automatic logic [CPLX_W-1:0] cplx_pack(input logic [DW-1:0] re,
                                                     input logic [DW-1:0] im);
        return {re, im};
    endfunction

endpackage

// File: rtl/sat_round_q14.sv
// Rounds a signed Q.14-scaled product half-up back to Q2.14 and saturates to DW bits.
// Purely combinational; the caller supplies the register stage.
module sat_round_q14
    import fft_pkg::*;
(
    input  logic signed [PW-1:0] i_prod,
    output logic        [DW-1:0] o_res,
    output logic                 o_sat
);

    localparam int SHW = PW + 1 - FRAC;
    localparam logic signed [SHW-1:0] MAX_V = SHW'(2 ** (DW - 1) - 1);
    localparam logic signed [SHW-1:0] MIN_V = SHW'(-(2 ** (DW - 1)));

    logic signed [PW:0]    w_biased;
    logic signed [SHW-1:0] w_shifted;

    // One guard bit keeps the +2^13 bias from wrapping near full scale.
    assign w_biased  = $signed({i_prod[PW-1], i_prod}) + (PW + 1)'(2 ** (FRAC - 1));
    assign w_shifted = SHW'(w_biased >>> FRAC);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        o_sat = 1'b0;
        o_res = w_shifted[DW-1:0];
        if (w_shifted > MAX_V) begin
            o_sat = 1'b1;
            o_res = {1'b0, {(DW - 1){1'b1}}};
        end else if (w_shifted < MIN_V) begin
            o_sat = 1'b1;
            o_res = {1'b1, {(DW - 1){1'b0}}};
        end
    end

endmodule

// File: rtl/complex_mult_twiddle_wn1_inv_pipe_32b.sv
// Three-stage valid/ready pipeline multiplying a packed complex sample by (1+j)/sqrt2.
// S1 forms sum/diff, S2 multiplies by K_HSQRT2, S3 rounds, saturates and drives the outputs.
module complex_mult_twiddle_wn1_inv_pipe_32b
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CPLX_W-1:0] A32,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CPLX_W-1:0] R32,
    output logic              sat
);

    localparam logic signed [PW-1:0] K_EXT = PW'(K_HSQRT2);

    logic                 r_v1, r_v2, r_v3;
    logic signed [SW-1:0] r_sum, r_diff;
    logic signed [PW-1:0] r_p_re, r_p_im;
    logic [CPLX_W-1:0]    r_r32;
    logic                 r_sat;

    logic                 w_ld1, w_ld2, w_ld3;
    logic [DW-1:0]        w_re, w_im;
    logic                 w_sat_re, w_sat_im;

    // A stage refills when empty or when its contents move on; readiness ripples back from out_ready.
    assign w_ld3    = !r_v3 || out_ready;
    assign w_ld2    = !r_v2 || w_ld3;
    assign w_ld1    = !r_v1 || w_ld2;
    assign in_ready = w_ld1;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_sum  <= '0;
            r_diff <= '0;
        end else if (w_ld1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_sum  <= SW'(cplx_re(A32)) + SW'(cplx_im(A32));
                r_diff <= SW'(cplx_re(A32)) - SW'(cplx_im(A32));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_p_re <= '0;
            r_p_im <= '0;
        end else if (w_ld2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_p_re <= PW'(r_diff) * K_EXT;
                r_p_im <= PW'(r_sum) * K_EXT;
            end
        end
    end

    sat_round_q14 u_round_re (
        .i_prod (r_p_re),
        .o_res  (w_re),
        .o_sat  (w_sat_re)
    );

    sat_round_q14 u_round_im (
        .i_prod (r_p_im),
        .o_res  (w_im),
        .o_sat  (w_sat_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3  <= 1'b0;
            r_r32 <= '0;
            r_sat <= 1'b0;
        end else if (w_ld3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_r32 <= cplx_pack(w_re, w_im);
                r_sat <= w_sat_re | w_sat_im;
            end
        end
    end

    assign out_valid = r_v3;
    assign R32       = r_r32;
    assign sat       = r_sat;

endmodule

// File: tb/tb_complex_mult_twiddle_wn1_inv_pipe_32b.sv
// Bench for the W8^-1 twiddle multiplier: hand-computed vectors, random streams and
// stall/reset sequences, all scored against an integer model of (a_re -/+ a_im)*K rounded.
module tb_complex_mult_twiddle_wn1_inv_pipe_32b;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A32;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] R32;
    logic        sat;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;

    logic [32:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [32:0] held;

    typedef struct {
        logic [31:0] a;
        logic [31:0] r;
        logic        s;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    complex_mult_twiddle_wn1_inv_pipe_32b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A32       (A32),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R32       (R32),
        .sat       (sat)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat16(input longint v, inout logic s);
        if (v > 32767) begin
            s = 1'b1;
            return 32767;
        end
        if (v < -32768) begin
            s = 1'b1;
            return -32768;
        end
        return v;
    endfunction

    // Reference: floor((x*11585 + 8192) / 2^14) with clipping to 16-bit signed.
    function automatic logic [32:0] model(input logic [31:0] a);
        longint re, im, yr, yi;
        logic   s;
        logic [15:0] r16, i16;
        re = longint'($signed(a[31:16]));
        im = longint'($signed(a[15:0]));
        s  = 1'b0;
        yr = sat16((((re - im) * 11585) + 8192) >>> 14, s);
        yi = sat16((((re + im) * 11585) + 8192) >>> 14, s);
        r16 = yr[15:0];
        i16 = yi[15:0];
        return {s, r16, i16};
    endfunction

    always @(negedge rst_n) begin
        exp_q.delete();
        stall_prev = 1'b0;
    end

    // Scoreboard: at the falling edge the handshake signals show what the next rising edge will transfer.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got R32=%h with no sample in flight", R32);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_r32", 64'(R32), 64'(e[31:0]));
                    check("stream_sat", 64'(sat), 64'(e[32]));
                end
            end
            if (stall_prev)
                check("stall_hold", 64'({sat, R32}), 64'(held));
            if (in_valid && in_ready) begin
                exp_q.push_back(model(A32));
                n_acc++;
            end
            stall_prev = out_valid && !out_ready;
            held       = {sat, R32};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int gaps;
        int acc0;

        vecs[0] = '{32'h4000_0000, 32'h2D41_2D41, 1'b0};
        vecs[1] = '{32'h0000_4000, 32'hD2BF_2D41, 1'b0};
        vecs[2] = '{32'h7FFF_7FFF, 32'h0000_7FFF, 1'b1};
        vecs[3] = '{32'h8000_7FFF, 32'h8000_FFFF, 1'b1};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[5] = '{32'hC000_0000, 32'hD2BF_D2BF, 1'b0};
        vecs[6] = '{32'h8000_8000, 32'h0000_8000, 1'b1};
        vecs[7] = '{32'h0001_0000, 32'h0001_0001, 1'b0};
        vecs[8] = '{32'hFFFF_0000, 32'hFFFF_FFFF, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A32       = '0;
        #12;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_r32", 64'(R32), 64'd0);
        check("reset_sat", 64'(sat), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Directed vectors, each checked for exact 3-edge latency.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            A32      = vecs[i].a;
            check("vec_in_ready", 64'(in_ready), 64'd1);
            tick();
            in_valid = 1'b0;
            A32      = $urandom();
            tick();
            check("vec_latency_early", 64'(out_valid), 64'd0);
            tick();
            check("vec_latency_valid", 64'(out_valid), 64'd1);
            check("vec_r32", 64'(R32), 64'(vecs[i].r));
            check("vec_sat", 64'(sat), 64'(vecs[i].s));
        end
        drain("vec_drain");

        // Back-to-back stream of 64 random samples at full rate.
        gaps = 0;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            A32      = $urandom();
            if (!in_ready) gaps++;
            tick();
        end
        in_valid = 1'b0;
        check("stream_no_gaps", 64'(gaps), 64'd0);
        drain("stream_drain");

        // Stall: out_ready low for 6 clocks with continuous input.
        out_ready = 1'b0;
        acc0      = n_acc;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            A32      = $urandom();
            tick();
        end
        check("stall_accepts", 64'(n_acc - acc0), 64'd3);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            A32 = $urandom();
            tick();
        end
        in_valid = 1'b0;
        drain("stall_drain");

        // Random valid/ready traffic.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            A32       = $urandom();
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("random_drain");

        // Reset with three samples in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            A32      = $urandom();
            tick();
        end
        in_valid = 1'b0;
        check("pre_reset_out_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'd0);
        check("async_reset_r32", 64'(R32), 64'd0);
        check("async_reset_sat", 64'(sat), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) tick();
        check("post_reset_no_stale", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        A32      = 32'h4000_0000;
        tick();
        in_valid = 1'b0;
        drain("post_reset_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
